// File: rtl/tlcd_pkg.sv
// Shared constants, target enum and address helpers for the Text LCD bus decoder.
package tlcd_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned AC_W        = 7;
   localparam int unsigned CG_AW       = 6;
   localparam int unsigned CG_DW       = 5;
   localparam int unsigned ROW_CELLS   = 16;
   localparam int unsigned NUM_CELLS   = 32;
   localparam int unsigned CELL_IDX_W  = 5;
   localparam int unsigned TEXT_W      = 128;
   localparam int unsigned WR_CNT_W    = 16;

   localparam logic [DATA_W-1:0] SPACE_CODE = 8'h20;

   localparam logic [DATA_W-1:0] OP_DDRAM_MASK  = 8'h80;
   localparam logic [DATA_W-1:0] OP_DDRAM_MATCH = 8'h80;
   localparam logic [DATA_W-1:0] OP_CGRAM_MASK  = 8'hC0;
   localparam logic [DATA_W-1:0] OP_CGRAM_MATCH = 8'h40;
   localparam logic [DATA_W-1:0] OP_FUNC_MASK   = 8'hE0;
   localparam logic [DATA_W-1:0] OP_FUNC_MATCH  = 8'h20;
   localparam logic [DATA_W-1:0] OP_SHIFT_MASK  = 8'hF0;
   localparam logic [DATA_W-1:0] OP_SHIFT_MATCH = 8'h10;
   localparam logic [DATA_W-1:0] OP_DISP_MASK   = 8'hF8;
   localparam logic [DATA_W-1:0] OP_DISP_MATCH  = 8'h08;
   localparam logic [DATA_W-1:0] OP_ENTRY_MASK  = 8'hFC;
   localparam logic [DATA_W-1:0] OP_ENTRY_MATCH = 8'h04;
   localparam logic [DATA_W-1:0] OP_HOME_MASK   = 8'hFE;
   localparam logic [DATA_W-1:0] OP_HOME_MATCH  = 8'h02;
   localparam logic [DATA_W-1:0] OP_CLEAR_MASK  = 8'hFF;
   localparam logic [DATA_W-1:0] OP_CLEAR_MATCH = 8'h01;

   localparam logic [AC_W-1:0] DD_ROW0_LO     = 7'h00;
   localparam logic [AC_W-1:0] DD_ROW0_VIS_HI = 7'h0F;
   localparam logic [AC_W-1:0] DD_ROW0_HI     = 7'h27;
   localparam logic [AC_W-1:0] DD_ROW1_LO     = 7'h40;
   localparam logic [AC_W-1:0] DD_ROW1_VIS_HI = 7'h4F;
   localparam logic [AC_W-1:0] DD_ROW1_HI     = 7'h67;

   typedef enum logic {TGT_DDRAM, TGT_CGRAM} tgt_e;

   function automatic logic op_is(input logic [DATA_W-1:0] d,
                                  input logic [DATA_W-1:0] mask,
                                  input logic [DATA_W-1:0] match);
      return (d & mask) == match;
   endfunction

   function automatic logic ddram_legal(input logic [AC_W-1:0] a);
      return (a <= DD_ROW0_HI) || ((a >= DD_ROW1_LO) && (a <= DD_ROW1_HI));
   endfunction

   function automatic logic ddram_visible(input logic [AC_W-1:0] a);
      return (a <= DD_ROW0_VIS_HI) || ((a >= DD_ROW1_LO) && (a <= DD_ROW1_VIS_HI));
   endfunction

   // Row select comes from bit 6, column from the low nibble.
   function automatic logic [CELL_IDX_W-1:0] ddram_index(input logic [AC_W-1:0] a);
      return {a[6], a[3:0]};
   endfunction

   function automatic logic [AC_W-1:0] ddram_step(input logic [AC_W-1:0] a, input logic inc);
      logic [AC_W-1:0] r;
      if (inc) begin
         if (a == DD_ROW0_HI)      r = DD_ROW1_LO;
         else if (a == DD_ROW1_HI) r = DD_ROW0_LO;
         else                      r = a + AC_W'(1);
      end else begin
         if (a == DD_ROW0_LO)      r = DD_ROW1_HI;
         else if (a == DD_ROW1_LO) r = DD_ROW0_HI;
         else                      r = a - AC_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/tlcd_strobe_sync.sv
// Synchronizes the TLCD bus and emits a one-cycle strobe with the bus captured on each E falling edge.
module tlcd_strobe_sync
   import tlcd_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              e_i,
   input  logic              rs_i,
   input  logic              rw_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              strobe_o,
   output logic              rs_o,
   output logic              rw_o,
   output logic [DATA_W-1:0] data_o
);

   localparam int unsigned BUS_W = DATA_W + 3;
   localparam int unsigned CAP_W = DATA_W + 2;

   logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q, sync_d;
   logic                              e_prev_q, e_prev_d;
   logic                              strobe_q, strobe_d;
   logic [CAP_W-1:0]                  cap_q, cap_d;
   logic [BUS_W-1:0]                  last;
   logic                              fall;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {e_i, rs_i, rw_i, data_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      last     = sync_q[SYNC_STAGES-1];
      fall     = e_prev_q & ~last[BUS_W-1];
      e_prev_d = last[BUS_W-1];
      strobe_d = fall;
      cap_d    = fall ? last[CAP_W-1:0] : cap_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         e_prev_q <= 1'b0;
         strobe_q <= 1'b0;
         cap_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         e_prev_q <= e_prev_d;
         strobe_q <= strobe_d;
         cap_q    <= cap_d;
      end
   end

   assign strobe_o = strobe_q;
   assign rs_o     = cap_q[CAP_W-1];
   assign rw_o     = cap_q[CAP_W-2];
   assign data_o   = cap_q[DATA_W-1:0];

endmodule

// File: rtl/tlcd_bus_decoder.sv
// Passive HD44780-style write-bus decoder keeping a shadow 2x16 DDRAM and display state.
// Define TLCD_DEC_CGRAM_EN to build the 64x5 CGRAM shadow and its registered readback.
module tlcd_bus_decoder
   import tlcd_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                TLCD_E,
   input  logic                TLCD_RS,
   input  logic                TLCD_RW,
   input  logic [DATA_W-1:0]   TLCD_DATA,
   input  logic [CG_AW-1:0]    CG_RADDR,
   output logic [TEXT_W-1:0]   TEXT_UPPER,
   output logic [TEXT_W-1:0]   TEXT_LOWER,
   output logic [CG_DW-1:0]    CG_RDATA,
   output logic                DISPLAY_ON,
   output logic                BUSY,
   output logic                FRAME_DONE,
   output logic                ERR_OVF,
   output logic                ERR_ADDR,
   output logic [WR_CNT_W-1:0] WR_COUNT
);

   logic              strb, strb_rs, strb_rw;
   logic [DATA_W-1:0] strb_data;

   tlcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (CLK),
      .rst      (RST),
      .e_i      (TLCD_E),
      .rs_i     (TLCD_RS),
      .rw_i     (TLCD_RW),
      .data_i   (TLCD_DATA),
      .strobe_o (strb),
      .rs_o     (strb_rs),
      .rw_o     (strb_rw),
      .data_o   (strb_data)
   );

   logic [DATA_W-1:0]     cell_q [NUM_CELLS];
   logic [DATA_W-1:0]     cell_d [NUM_CELLS];
   logic [AC_W-1:0]       ac_q, ac_d;
   logic                  inc_q, inc_d;
   tgt_e                  tgt_q, tgt_d;
   logic                  disp_on_q, disp_on_d;
   logic                  busy_q, busy_d;
   logic [CELL_IDX_W-1:0] sweep_q, sweep_d;
   logic                  frame_done_q, frame_done_d;
   logic                  err_ovf_q, err_ovf_d;
   logic                  err_addr_q, err_addr_d;
   logic [WR_CNT_W-1:0]   wr_count_q, wr_count_d;
   logic                  pend_full_q, pend_full_d;
   logic                  pend_rs_q, pend_rs_d;
   logic [DATA_W-1:0]     pend_data_q, pend_data_d;

   logic                  exec_pend, new_wr, exec_vld, exec_rs;
   logic [DATA_W-1:0]     exec_data;
   logic [CG_AW-1:0]      cg_next;
   logic [WR_CNT_W-1:0]   wr_count_inc;

`ifdef TLCD_DEC_CGRAM_EN
   logic [CG_DW-1:0] cg_mem_q [2**CG_AW];
   logic [CG_DW-1:0] cg_mem_d [2**CG_AW];
   logic [CG_DW-1:0] cg_rdata_q, cg_rdata_d;
`endif

   // Pending/bus arbitration, clear sweep and command execution.
   always_comb begin
      cell_d       = cell_q;
      ac_d         = ac_q;
      inc_d        = inc_q;
      tgt_d        = tgt_q;
      disp_on_d    = disp_on_q;
      busy_d       = busy_q;
      sweep_d      = sweep_q;
      frame_done_d = 1'b0;
      err_ovf_d    = err_ovf_q;
      err_addr_d   = err_addr_q;
      wr_count_d   = wr_count_q;
      pend_full_d  = pend_full_q;
      pend_rs_d    = pend_rs_q;
      pend_data_d  = pend_data_q;
`ifdef TLCD_DEC_CGRAM_EN
      cg_mem_d     = cg_mem_q;
`endif

      wr_count_inc = (wr_count_q == {WR_CNT_W{1'b1}}) ? wr_count_q : wr_count_q + WR_CNT_W'(1);
      exec_pend    = pend_full_q & ~busy_q;
      new_wr       = strb & ~strb_rw;
      exec_vld     = exec_pend | (new_wr & ~busy_q & ~pend_full_q);
      exec_rs      = exec_pend ? pend_rs_q   : strb_rs;
      exec_data    = exec_pend ? pend_data_q : strb_data;
      cg_next      = inc_q ? ac_q[CG_AW-1:0] + CG_AW'(1) : ac_q[CG_AW-1:0] - CG_AW'(1);

      if (exec_pend) pend_full_d = 1'b0;

      // A strobe that cannot run now parks in the pending slot; the slot holds one.
      if (new_wr) begin
         if (busy_q || pend_full_q) begin
            if (pend_full_q && !exec_pend) begin
               err_ovf_d = 1'b1;
            end else begin
               pend_full_d = 1'b1;
               pend_rs_d   = strb_rs;
               pend_data_d = strb_data;
               wr_count_d  = wr_count_inc;
            end
         end else begin
            wr_count_d = wr_count_inc;
         end
      end

      if (busy_q) begin
         cell_d[sweep_q] = SPACE_CODE;
         sweep_d         = sweep_q + CELL_IDX_W'(1);
         if (sweep_q == CELL_IDX_W'(NUM_CELLS - 1)) begin
            busy_d = 1'b0;
            ac_d   = DD_ROW0_LO;
            inc_d  = 1'b1;
            tgt_d  = TGT_DDRAM;
         end
      end

      if (exec_vld) begin
         if (exec_rs) begin
            if (tgt_q == TGT_DDRAM) begin
               if (ddram_visible(ac_q)) cell_d[ddram_index(ac_q)] = exec_data;
               if (ac_q == DD_ROW1_VIS_HI) frame_done_d = 1'b1;
               ac_d = ddram_step(ac_q, inc_q);
            end else begin
`ifdef TLCD_DEC_CGRAM_EN
               cg_mem_d[ac_q[CG_AW-1:0]] = exec_data[CG_DW-1:0];
`endif
               ac_d = AC_W'(cg_next);
            end
         end else if (op_is(exec_data, OP_DDRAM_MASK, OP_DDRAM_MATCH)) begin
            tgt_d = TGT_DDRAM;
            if (ddram_legal(exec_data[AC_W-1:0])) begin
               ac_d = exec_data[AC_W-1:0];
            end else begin
               ac_d       = DD_ROW0_LO;
               err_addr_d = 1'b1;
            end
         end else if (op_is(exec_data, OP_CGRAM_MASK, OP_CGRAM_MATCH)) begin
            tgt_d = TGT_CGRAM;
            ac_d  = AC_W'(exec_data[CG_AW-1:0]);
         end else if (op_is(exec_data, OP_FUNC_MASK, OP_FUNC_MATCH) ||
                      op_is(exec_data, OP_SHIFT_MASK, OP_SHIFT_MATCH)) begin
            ac_d = ac_q;
         end else if (op_is(exec_data, OP_DISP_MASK, OP_DISP_MATCH)) begin
            disp_on_d = exec_data[2];
         end else if (op_is(exec_data, OP_ENTRY_MASK, OP_ENTRY_MATCH)) begin
            inc_d = exec_data[1];
         end else if (op_is(exec_data, OP_HOME_MASK, OP_HOME_MATCH)) begin
            ac_d  = DD_ROW0_LO;
            tgt_d = TGT_DDRAM;
         end else if (op_is(exec_data, OP_CLEAR_MASK, OP_CLEAR_MATCH)) begin
            busy_d  = 1'b1;
            sweep_d = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_CELLS; i++) cell_q[i] <= SPACE_CODE;
         ac_q         <= DD_ROW0_LO;
         inc_q        <= 1'b1;
         tgt_q        <= TGT_DDRAM;
         disp_on_q    <= 1'b0;
         busy_q       <= 1'b0;
         sweep_q      <= '0;
         frame_done_q <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_addr_q   <= 1'b0;
         wr_count_q   <= '0;
         pend_full_q  <= 1'b0;
         pend_rs_q    <= 1'b0;
         pend_data_q  <= '0;
      end else begin
         cell_q       <= cell_d;
         ac_q         <= ac_d;
         inc_q        <= inc_d;
         tgt_q        <= tgt_d;
         disp_on_q    <= disp_on_d;
         busy_q       <= busy_d;
         sweep_q      <= sweep_d;
         frame_done_q <= frame_done_d;
         err_ovf_q    <= err_ovf_d;
         err_addr_q   <= err_addr_d;
         wr_count_q   <= wr_count_d;
         pend_full_q  <= pend_full_d;
         pend_rs_q    <= pend_rs_d;
         pend_data_q  <= pend_data_d;
      end
   end

`ifdef TLCD_DEC_CGRAM_EN
   always_comb cg_rdata_d = cg_mem_q[CG_RADDR];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 2**CG_AW; i++) cg_mem_q[i] <= '0;
         cg_rdata_q <= '0;
      end else begin
         cg_mem_q   <= cg_mem_d;
         cg_rdata_q <= cg_rdata_d;
      end
   end

   assign CG_RDATA = cg_rdata_q;
`else
   logic unused_cg_raddr;
   assign unused_cg_raddr = ^CG_RADDR;
   assign CG_RDATA        = '0;
`endif

   // Column 0 sits in the top byte of each row string.
   always_comb begin
      TEXT_UPPER = '0;
      TEXT_LOWER = '0;
      for (int c = 0; c < ROW_CELLS; c++) begin
         TEXT_UPPER[TEXT_W-1-8*c -: 8] = cell_q[c];
         TEXT_LOWER[TEXT_W-1-8*c -: 8] = cell_q[ROW_CELLS+c];
      end
   end

   assign DISPLAY_ON = disp_on_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = frame_done_q;
   assign ERR_OVF    = err_ovf_q;
   assign ERR_ADDR   = err_addr_q;
   assign WR_COUNT   = wr_count_q;

endmodule

// File: tb/tb_tlcd_bus_decoder.sv
// Directed bench for tlcd_bus_decoder: drives LCD bus cycles and checks text, flags and counters.
module tb_tlcd_bus_decoder;

   logic         CLK;
   logic         RST;
   logic         TLCD_E;
   logic         TLCD_RS;
   logic         TLCD_RW;
   logic [7:0]   TLCD_DATA;
   logic [5:0]   CG_RADDR;
   logic [127:0] TEXT_UPPER;
   logic [127:0] TEXT_LOWER;
   logic [4:0]   CG_RDATA;
   logic         DISPLAY_ON;
   logic         BUSY;
   logic         FRAME_DONE;
   logic         ERR_OVF;
   logic         ERR_ADDR;
   logic [15:0]  WR_COUNT;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_wr   = 0;
   int fd_cnt   = 0;
   int busy_cyc = 0;

   localparam logic [127:0] SPACES = {16{8'h20}};

   tlcd_bus_decoder #(.SYNC_STAGES(2)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .TLCD_E     (TLCD_E),
      .TLCD_RS    (TLCD_RS),
      .TLCD_RW    (TLCD_RW),
      .TLCD_DATA  (TLCD_DATA),
      .CG_RADDR   (CG_RADDR),
      .TEXT_UPPER (TEXT_UPPER),
      .TEXT_LOWER (TEXT_LOWER),
      .CG_RDATA   (CG_RDATA),
      .DISPLAY_ON (DISPLAY_ON),
      .BUSY       (BUSY),
      .FRAME_DONE (FRAME_DONE),
      .ERR_OVF    (ERR_OVF),
      .ERR_ADDR   (ERR_ADDR),
      .WR_COUNT   (WR_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
      if (BUSY)       busy_cyc <= busy_cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] row_c0(input logic [7:0] c0);
      logic [127:0] r;
      r = SPACES;
      r[127:120] = c0;
      return r;
   endfunction

   // One bus cycle: E high 4 clocks, E low 4 clocks, bus held stable throughout.
   task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
      @(negedge CLK);
      TLCD_RS   = rs;
      TLCD_RW   = rw;
      TLCD_DATA = d;
      TLCD_E    = 1'b1;
      repeat (4) @(negedge CLK);
      TLCD_E = 1'b0;
      repeat (4) @(negedge CLK);
      #1;
   endtask

   initial begin
      logic [127:0] exp_low;
      int           fd_base;
      int           busy_base;
      logic [4:0]   exp_cg;

      RST = 1'b1; TLCD_E = 1'b0; TLCD_RS = 1'b0; TLCD_RW = 1'b0;
      TLCD_DATA = 8'h00; CG_RADDR = 6'd0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check_eq("rst_upper",    TEXT_UPPER, SPACES);
      check_eq("rst_lower",    TEXT_LOWER, SPACES);
      check_eq("rst_disp",     128'(DISPLAY_ON), 128'(0));
      check_eq("rst_wr_count", 128'(WR_COUNT), 128'(0));
      check_eq("rst_busy",     128'(BUSY), 128'(0));
      check_eq("rst_err_addr", 128'(ERR_ADDR), 128'(0));

      // Display-on with exact latency: effect after the 4th edge that sees E low.
      @(negedge CLK);
      TLCD_RS = 1'b0; TLCD_RW = 1'b0; TLCD_DATA = 8'h0C; TLCD_E = 1'b1;
      repeat (4) @(negedge CLK);
      TLCD_E = 1'b0;
      repeat (3) @(negedge CLK);
      check_eq("lat_disp_early", 128'(DISPLAY_ON), 128'(0));
      @(negedge CLK);
      check_eq("lat_disp_on", 128'(DISPLAY_ON), 128'(1));
      exp_wr = 1;
      repeat (2) @(negedge CLK);

      bus_cycle(1'b0, 1'b0, 8'hC0); exp_wr++;
      bus_cycle(1'b1, 1'b0, 8'h41); exp_wr++;
      check_eq("row1_col0", 128'(TEXT_LOWER[127:120]), 128'(8'h41));
      bus_cycle(1'b1, 1'b0, 8'h42); exp_wr++;
      check_eq("row1_col1", 128'(TEXT_LOWER[119:112]), 128'(8'h42));
      check_eq("wr_count_a", 128'(WR_COUNT), 128'(exp_wr));
      bus_cycle(1'b1, 1'b1, 8'h77);
      check_eq("rw_read_count", 128'(WR_COUNT), 128'(exp_wr));
      check_eq("rw_read_upper", TEXT_UPPER, SPACES);

      // Fill row 1; the 16th write hits 0x4F, the 17th lands off-screen at 0x50.
      bus_cycle(1'b0, 1'b0, 8'hC0); exp_wr++;
      fd_base = fd_cnt;
      for (int i = 0; i < 17; i++) begin
         bus_cycle(1'b1, 1'b0, 8'(8'h30 + i)); exp_wr++;
         if (i == 14) check_eq("fd_before_16th", 128'(fd_cnt - fd_base), 128'(0));
         if (i == 15) check_eq("fd_on_16th",     128'(fd_cnt - fd_base), 128'(1));
      end
      check_eq("fd_total", 128'(fd_cnt - fd_base), 128'(1));
      exp_low = '0;
      for (int i = 0; i < 16; i++) exp_low[127-8*i -: 8] = 8'(8'h30 + i);
      check_eq("row1_filled", TEXT_LOWER, exp_low);
      check_eq("row0_untouched", TEXT_UPPER, SPACES);

      // Clear sweep with one held strobe and one overflowing strobe.
      busy_base = busy_cyc;
      bus_cycle(1'b0, 1'b0, 8'h01); exp_wr++;
      check_eq("busy_rise", 128'(BUSY), 128'(1));
      bus_cycle(1'b1, 1'b0, 8'h58); exp_wr++;
      bus_cycle(1'b1, 1'b0, 8'h59);
      check_eq("busy_still", 128'(BUSY), 128'(1));
      for (int i = 0; i < 100 && BUSY; i++) @(negedge CLK);
      check_eq("busy_fall", 128'(BUSY), 128'(0));
      repeat (2) @(negedge CLK);
      #1;
      check_eq("busy_len", 128'(busy_cyc - busy_base), 128'(32));
      check_eq("clr_upper", TEXT_UPPER, row_c0(8'h58));
      check_eq("clr_lower", TEXT_LOWER, SPACES);
      check_eq("err_ovf", 128'(ERR_OVF), 128'(1));
      check_eq("wr_count_b", 128'(WR_COUNT), 128'(exp_wr));

      // Decrement wrap 0x00 -> 0x67, hole address, increment wrap 0x27 -> 0x40.
      bus_cycle(1'b0, 1'b0, 8'h04); exp_wr++;
      bus_cycle(1'b0, 1'b0, 8'h80); exp_wr++;
      bus_cycle(1'b1, 1'b0, 8'h5A); exp_wr++;
      check_eq("dec_col0", TEXT_UPPER, row_c0(8'h5A));
      bus_cycle(1'b1, 1'b0, 8'h59); exp_wr++;
      check_eq("dec_wrap_hidden_u", TEXT_UPPER, row_c0(8'h5A));
      check_eq("dec_wrap_hidden_l", TEXT_LOWER, SPACES);
      check_eq("err_addr_pre", 128'(ERR_ADDR), 128'(0));
      bus_cycle(1'b0, 1'b0, 8'hA8); exp_wr++;
      check_eq("err_addr", 128'(ERR_ADDR), 128'(1));
      bus_cycle(1'b0, 1'b0, 8'h06); exp_wr++;
      bus_cycle(1'b1, 1'b0, 8'h61); exp_wr++;
      check_eq("hole_ac_zero", TEXT_UPPER, row_c0(8'h61));
      bus_cycle(1'b0, 1'b0, 8'hA7); exp_wr++;
      bus_cycle(1'b1, 1'b0, 8'h64); exp_wr++;
      check_eq("ac27_hidden", TEXT_LOWER, SPACES);
      bus_cycle(1'b1, 1'b0, 8'h65); exp_wr++;
      check_eq("inc_wrap_40", TEXT_LOWER, row_c0(8'h65));
      bus_cycle(1'b0, 1'b0, 8'h08); exp_wr++;
      check_eq("disp_off", 128'(DISPLAY_ON), 128'(0));
      check_eq("wr_count_c", 128'(WR_COUNT), 128'(exp_wr));

      // CGRAM writes must not disturb DDRAM.
      bus_cycle(1'b0, 1'b0, 8'h40); exp_wr++;
      for (int i = 0; i < 8; i++) begin
         bus_cycle(1'b1, 1'b0, 8'h1F); exp_wr++;
      end
      check_eq("cg_upper_kept", TEXT_UPPER, row_c0(8'h61));
      check_eq("cg_lower_kept", TEXT_LOWER, row_c0(8'h65));
      check_eq("wr_count_d", 128'(WR_COUNT), 128'(exp_wr));
      for (int a = 0; a < 9; a++) begin
         @(negedge CLK);
         CG_RADDR = 6'(a);
         @(negedge CLK);
`ifdef TLCD_DEC_CGRAM_EN
         exp_cg = (a < 8) ? 5'h1F : 5'h00;
`else
         exp_cg = 5'h00;
`endif
         check_eq($sformatf("cg_rd_%0d", a), 128'(CG_RDATA), 128'(exp_cg));
      end

      // One-cycle reset restores everything.
      CG_RADDR = 6'd0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check_eq("rst2_upper",    TEXT_UPPER, SPACES);
      check_eq("rst2_lower",    TEXT_LOWER, SPACES);
      check_eq("rst2_disp",     128'(DISPLAY_ON), 128'(0));
      check_eq("rst2_wr_count", 128'(WR_COUNT), 128'(0));
      check_eq("rst2_err_ovf",  128'(ERR_OVF), 128'(0));
      check_eq("rst2_err_addr", 128'(ERR_ADDR), 128'(0));
      @(negedge CLK);
      check_eq("rst2_cg_rdata", 128'(CG_RDATA), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
